// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle of the direct-mapped data cache.
// The slave modport is the cache's view; the master modport is the pipeline/memory side.
interface dcache_controller_if;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_memread_i;
    logic         cpu_memwrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    modport slave (
        input  cpu_addr_i, cpu_data_i, cpu_memread_i, cpu_memwrite_i,
        input  mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    modport master (
        output cpu_addr_i, cpu_data_i, cpu_memread_i, cpu_memwrite_i,
        output mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with 256-bit lines.
// Hits finish with no stall; misses write back a dirty victim and refill over a req/ack bus.
module dcache_controller #(
    parameter int LINES   = 16,
    parameter int INDEX_W = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    dcache_controller_if.slave bus
);
    localparam int TAG_W = 32 - 5 - INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

    state_t             state_reg, state_next;
    logic [LINES-1:0]   valid_reg, dirty_reg;
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [255:0]       line_rd;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         word_sel;
    logic               request, hit, hit_write, alloc_fire;

    logic               stall;
    logic [31:0]        cpu_data;
    logic               mem_enable, mem_write;
    logic [31:0]        mem_addr;
    logic [255:0]       mem_data;
    logic               unused_bits;

    assign index       = bus.cpu_addr_i[5+INDEX_W-1:5];
    assign req_tag     = bus.cpu_addr_i[31:5+INDEX_W];
    assign word_sel    = bus.cpu_addr_i[4:2];
    assign unused_bits = ^bus.cpu_addr_i[1:0];

    assign request    = bus.cpu_memread_i | bus.cpu_memwrite_i;
    assign hit        = request & valid_reg[index] & (tag_mem[index] == req_tag);
    // A simultaneous read and write is treated as a store.
    assign hit_write  = (state_reg == IDLE) & hit & bus.cpu_memwrite_i;
    assign alloc_fire = (state_reg == ALLOCATE) & bus.mem_ack_i;

    // One 32-bit bank per word lets a store touch a single word while a refill writes all eight.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : gen_bank
            logic [31:0] bank [LINES];

            always_ff @(posedge clk_i) begin
                if (alloc_fire) begin
                    bank[index] <= bus.mem_data_i[32*gi +: 32];
                end else if (hit_write && (word_sel == 3'(gi))) begin
                    bank[index] <= bus.cpu_data_i;
                end
            end

            assign line_rd[32*gi +: 32] = bank[index];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            tag_mem[index] <= req_tag;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            valid_reg <= '0;
            dirty_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (alloc_fire) begin
                valid_reg[index] <= 1'b1;
                dirty_reg[index] <= 1'b0;
            end else if (hit_write) begin
                dirty_reg[index] <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        cpu_data   = '0;
        mem_enable = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        case (state_reg)
            IDLE: begin
                if (request) begin
                    if (hit) begin
                        cpu_data = line_rd[{word_sel, 5'b0} +: 32];
                    end else begin
                        stall      = 1'b1;
                        state_next = (valid_reg[index] & dirty_reg[index]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                stall      = 1'b1;
                mem_enable = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_mem[index], index, 5'b0};
                mem_data   = line_rd;
                if (bus.mem_ack_i) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                stall      = 1'b1;
                mem_enable = 1'b1;
                mem_addr   = {req_tag, index, 5'b0};
                if (bus.mem_ack_i) begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                stall      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // While reset is held the pipeline is released even if it keeps presenting a request.
    assign bus.cpu_stall_o  = stall & ~rst_i;
    assign bus.cpu_data_o   = cpu_data & {32{~rst_i}};
    assign bus.mem_enable_o = mem_enable;
    assign bus.mem_write_o  = mem_write;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.mem_data_o   = mem_data;
endmodule
